// File: rtl/code_loader_if.sv
// Byte-stream input and code-memory write port of the program loader.
// master: the loader side; slave: byte source and code memory.
interface code_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/code_loader.sv
// Loads a byte-serial program image (16-bit count, LE words, 8-bit sum)
// into code memory while holding the CPU off.
module code_loader #(
  parameter int unsigned CODE_WORDS      = 1024,
  parameter int unsigned CODE_ADDR_WIDTH = 10,
  parameter int unsigned CODE_WIDTH      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  code_loader_if.master bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int unsigned LEN_WIDTH  = 16;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned BUF_WIDTH  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic                       in_ready_q, in_ready_d;
  logic                       mem_we_q, mem_we_d;
  logic [CODE_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CODE_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                       cpu_hold_q, cpu_hold_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [LEN_WIDTH-1:0]       words_q, words_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [BYTE_WIDTH-1:0]      csum_q, csum_d;
  logic [1:0]                 byte_cnt_q, byte_cnt_d;
  logic [BUF_WIDTH-1:0]       word_buf_q, word_buf_d;

  logic                  xfer_c;
  logic [LEN_WIDTH-1:0]  len_full_c;
  logic                  len_too_big_c;
  logic                  len_zero_c;
  logic                  last_word_c;
  logic [BYTE_WIDTH-1:0] csum_next_c;
  logic                  csum_ok_c;

  assign xfer_c        = bus.in_valid & in_ready_q;
  assign len_full_c    = {bus.in_data, len_q[7:0]};
  assign len_too_big_c = 32'(len_full_c) > 32'(CODE_WORDS);
  assign len_zero_c    = (len_full_c == LEN_WIDTH'(0));
  assign last_word_c   = ((words_q + LEN_WIDTH'(1)) == len_q);
  assign csum_next_c   = csum_q + bus.in_data;
  assign csum_ok_c     = (bus.in_data == csum_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (xfer_c) state_d = S_LEN1;
      end
      S_LEN1: begin
        if (xfer_c) begin
          if (len_too_big_c)   state_d = S_ERR;
          else if (len_zero_c) state_d = S_CSUM;
          else                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c && (byte_cnt_q == 2'd3) && last_word_c) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (xfer_c) state_d = csum_ok_c ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    in_ready_d  = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                  (state_d == S_DATA) || (state_d == S_CSUM);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    words_d     = words_q;
    len_d       = len_q;
    csum_d      = csum_q;
    byte_cnt_d  = byte_cnt_q;
    word_buf_d  = word_buf_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          words_d    = '0;
          csum_d     = '0;
          byte_cnt_d = '0;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_LEN0: begin
        if (xfer_c) begin
          len_d[7:0] = bus.in_data;
          csum_d     = csum_next_c;
        end
      end
      S_LEN1: begin
        if (xfer_c) begin
          len_d[15:8] = bus.in_data;
          csum_d      = csum_next_c;
          if (len_too_big_c) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          csum_d     = csum_next_c;
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: word_buf_d[7:0]   = bus.in_data;
            2'd1: word_buf_d[15:8]  = bus.in_data;
            2'd2: word_buf_d[23:16] = bus.in_data;
            default: begin
              // Fourth byte completes the word: write it out directly
              mem_we_d    = 1'b1;
              mem_wdata_d = CODE_WIDTH'({bus.in_data, word_buf_q});
              mem_addr_d  = CODE_ADDR_WIDTH'(words_q);
              words_d     = words_q + LEN_WIDTH'(1);
            end
          endcase
        end
      end
      S_CSUM: begin
        if (xfer_c) begin
          busy_d = 1'b0;
          if (csum_ok_c) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            // Keep the CPU stalled on a corrupted image
            error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      words_q     <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      byte_cnt_q  <= '0;
      word_buf_q  <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      words_q     <= words_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      byte_cnt_q  <= byte_cnt_d;
      word_buf_q  <= word_buf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_loaded  = words_q;

endmodule
